// File: rtl/keyps2_scan.sv
// PS/2 set-2 scancode decoder. Folds the E0 (extended), F0 (break) and E1 (Pause)
// prefix sequences into single key events. Events are buffered in a show-ahead FIFO
// and delivered over a valid/ready handshake. The receiver enable is held low while
// the FIFO is full.
module keyps2_scan #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       rx_en,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       err_tick,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StPause} state_e;

    state_e        r_state, w_state_d;
    logic          r_ext, w_ext_d;
    logic          r_brk, w_brk_d;
    logic [2:0]    r_pcnt, w_pcnt_d;
    logic [TW-1:0] r_tcnt, w_tcnt_d;
    logic          r_err, w_err_d;
    logic          r_ovf, w_ovf_d;

    logic          w_dec_err;
    logic          w_push;
    logic [9:0]    w_push_data;

    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic          w_valid, w_full, w_pop, w_wr, w_drop;
    logic [9:0]    w_head;

    // Decoder next-state: prefix folding on byte ticks, timeout while mid-sequence.
    always_comb begin
        w_state_d   = r_state;
        w_ext_d     = r_ext;
        w_brk_d     = r_brk;
        w_pcnt_d    = r_pcnt;
        w_dec_err   = 1'b0;
        w_push      = 1'b0;
        w_push_data = 10'h000;
        if (rx_done_tick || r_state == StIdle) begin
            w_tcnt_d = '0;
        end else begin
            w_tcnt_d = r_tcnt + TW'(1);
        end

        if (rx_done_tick) begin
            case (r_state)
                StIdle: begin
                    case (rx_data)
                        8'hE0: begin
                            w_state_d = StExt;
                            w_ext_d   = 1'b1;
                        end
                        8'hF0: begin
                            w_state_d = StBrk;
                            w_brk_d   = 1'b1;
                        end
                        8'hE1: begin
                            w_state_d = StPause;
                            w_pcnt_d  = 3'd7;
                        end
                        8'h00, 8'hFF: w_dec_err = 1'b1;
                        default: begin
                            w_push      = 1'b1;
                            w_push_data = {r_ext, r_brk, rx_data};
                            w_ext_d     = 1'b0;
                            w_brk_d     = 1'b0;
                        end
                    endcase
                end
                StExt: begin
                    case (rx_data)
                        8'hF0: begin
                            w_state_d = StBrk;
                            w_brk_d   = 1'b1;
                        end
                        8'hE0: w_state_d = StExt;
                        8'h00, 8'hFF: begin
                            w_state_d = StIdle;
                            w_ext_d   = 1'b0;
                            w_brk_d   = 1'b0;
                            w_dec_err = 1'b1;
                        end
                        default: begin
                            w_push      = 1'b1;
                            w_push_data = {1'b1, 1'b0, rx_data};
                            w_state_d   = StIdle;
                            w_ext_d     = 1'b0;
                            w_brk_d     = 1'b0;
                        end
                    endcase
                end
                StBrk: begin
                    case (rx_data)
                        8'hE0, 8'hF0, 8'hE1, 8'h00, 8'hFF: begin
                            w_state_d = StIdle;
                            w_ext_d   = 1'b0;
                            w_brk_d   = 1'b0;
                            w_dec_err = 1'b1;
                        end
                        default: begin
                            w_push      = 1'b1;
                            w_push_data = {r_ext, 1'b1, rx_data};
                            w_state_d   = StIdle;
                            w_ext_d     = 1'b0;
                            w_brk_d     = 1'b0;
                        end
                    endcase
                end
                StPause: begin
                    // Pause is a fixed 8-byte sequence; contents are not checked.
                    w_pcnt_d = r_pcnt - 3'd1;
                    if (r_pcnt == 3'd1) begin
                        w_push      = 1'b1;
                        w_push_data = {1'b1, 1'b0, 8'hE1};
                        w_state_d   = StIdle;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end else if (r_state != StIdle && r_tcnt == TO_LAST) begin
            w_state_d = StIdle;
            w_ext_d   = 1'b0;
            w_brk_d   = 1'b0;
            w_tcnt_d  = '0;
            w_dec_err = 1'b1;
        end
    end

    // FIFO control and error/overflow next-state.
    always_comb begin
        w_valid = (r_count != '0);
        w_full  = (r_count == FULL_CNT);
        w_pop   = w_valid & key_ready;
        w_wr    = w_push & (~w_full | w_pop);
        w_drop  = w_push & w_full & ~w_pop;
        w_err_d = w_dec_err | w_drop;
        w_ovf_d = r_ovf | w_drop;
        w_head  = r_mem[r_rptr];
    end

    // Decoder and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_ext   <= 1'b0;
            r_brk   <= 1'b0;
            r_pcnt  <= 3'd0;
            r_tcnt  <= '0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_ext   <= w_ext_d;
            r_brk   <= w_brk_d;
            r_pcnt  <= w_pcnt_d;
            r_tcnt  <= w_tcnt_d;
            r_err   <= w_err_d;
            r_ovf   <= w_ovf_d;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    // FIFO storage; not reset since the outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    // Show-ahead outputs; zero while empty so stale entries never leak out.
    always_comb begin
        rx_en     = ~w_full;
        key_valid = w_valid;
        key_code  = w_valid ? w_head[7:0] : 8'h00;
        key_break = w_valid & w_head[8];
        key_ext   = w_valid & w_head[9];
        err_tick  = r_err;
        overflow  = r_ovf;
    end

endmodule
